// File: rtl/delta_rle_pkg.sv
// Shared definitions for the delta/RLE token stream.
// Token: MSB set = run of the previous pixel, clear = literal pixel.
package delta_rle_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    RUN    = 1'b1
  } rle_state_e;

  localparam int unsigned TOK_MAXW = 64;

  function automatic int unsigned tok_type_bit(
    input int unsigned busw
  );
    return busw - 1;
  endfunction

  function automatic logic tok_is_run(
    input logic [TOK_MAXW-1:0] tok,
    input int unsigned         busw
  );
    return tok[tok_type_bit(busw)];
  endfunction

  function automatic logic [TOK_MAXW-1:0] tok_count(
    input logic [TOK_MAXW-1:0] tok,
    input int unsigned         busw
  );
    logic [TOK_MAXW-1:0] m;
    m = (TOK_MAXW'(1) << tok_type_bit(busw)) - TOK_MAXW'(1);
    return tok & m;
  endfunction

  function automatic logic [TOK_MAXW-1:0] tok_pixel(
    input logic [TOK_MAXW-1:0] tok,
    input int unsigned         pixw
  );
    logic [TOK_MAXW-1:0] m;
    m = (TOK_MAXW'(1) << pixw) - TOK_MAXW'(1);
    return tok & m;
  endfunction

endpackage

// File: rtl/line_col_cnt.sv
// Column position of the pixel currently presented on the output.
// Advances once per output transfer and wraps at the line end.
module line_col_cnt #(
  parameter int unsigned LINE_W = 3840,
  localparam int unsigned CW = (LINE_W > 1) ? $clog2(LINE_W) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          inc,
  output logic [CW-1:0] col,
  output logic          last
);

  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;

  assign last = (col_q == CW'(LINE_W - 1));
  assign col  = col_q;

  always_comb begin
    col_d = col_q;
    if (inc) begin
      col_d = last ? '0 : col_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/delta_rle_rx.sv
// Run-length token expander: literals update the held pixel,
// run tokens repeat it; one registered output slot.
module delta_rle_rx
  import delta_rle_pkg::*;
#(
  parameter int unsigned PIXW   = 10,
  parameter int unsigned BUSW   = 16,
  parameter int unsigned LINE_W = 3840
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  input  logic [BUSW-1:0] s_data,
  output logic            s_ready,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [PIXW-1:0] m_px,
  output logic            m_last,
  output logic            run_active,
  output logic            err_zero_run,
  input  logic            err_clr
);

  localparam int unsigned CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  if (PIXW > BUSW - 1) begin : g_bad_pixw
    $error("delta_rle_rx: PIXW must not exceed BUSW-1");
  end
  if (LINE_W < 1) begin : g_bad_line
    $error("delta_rle_rx: LINE_W must be at least 1");
  end

  rle_state_e      state_q;
  logic [BUSW-2:0] remain_q;
  logic [PIXW-1:0] prev_q;
  logic [PIXW-1:0] px_q;
  logic            vld_q;
  logic            err_q;

  logic [TOK_MAXW-1:0] tok_w;
  logic                tok_run;
  logic [BUSW-2:0]     tok_cnt;
  logic [PIXW-1:0]     tok_px;
  logic                slot_free;
  logic                acc;
  logic [CW-1:0]       col_w;
  logic                last_w;
  logic                unused_col;

  assign tok_w   = TOK_MAXW'(s_data);
  assign tok_run = tok_is_run(tok_w, BUSW);
  assign tok_cnt = (BUSW-1)'(tok_count(tok_w, BUSW));
  assign tok_px  = PIXW'(tok_pixel(tok_w, PIXW));

  assign slot_free = !vld_q || m_ready;
  // Gated by rstn so the source sees no acceptance while held in reset.
  assign s_ready   = rstn && (state_q == ACCEPT) && slot_free;
  assign acc       = s_valid && s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ACCEPT;
      remain_q <= '0;
      prev_q   <= '0;
      px_q     <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (slot_free) begin
        vld_q <= 1'b0;
      end
      if (err_clr) begin
        err_q <= 1'b0;
      end
      unique case (state_q)
        ACCEPT: begin
          if (acc) begin
            if (!tok_run) begin
              vld_q  <= 1'b1;
              px_q   <= tok_px;
              prev_q <= tok_px;
            end else if (tok_cnt == '0) begin
              err_q <= 1'b1;
            end else begin
              vld_q <= 1'b1;
              px_q  <= prev_q;
              if (tok_cnt != (BUSW-1)'(1)) begin
                remain_q <= tok_cnt - (BUSW-1)'(1);
                state_q  <= RUN;
              end
            end
          end
        end
        RUN: begin
          if (slot_free) begin
            vld_q    <= 1'b1;
            px_q     <= prev_q;
            remain_q <= remain_q - (BUSW-1)'(1);
            if (remain_q == (BUSW-1)'(1)) begin
              state_q <= ACCEPT;
            end
          end
        end
      endcase
    end
  end

  line_col_cnt #(
    .LINE_W (LINE_W)
  ) u_col (
    .clk  (clk),
    .rstn (rstn),
    .inc  (vld_q && m_ready),
    .col  (col_w),
    .last (last_w)
  );

  assign unused_col   = ^col_w;
  assign m_valid      = vld_q;
  assign m_px         = px_q;
  assign m_last       = vld_q && last_w;
  assign run_active   = (state_q == RUN);
  assign err_zero_run = err_q;

endmodule

// File: tb/tb_delta_rle_rx.sv
// Bench for delta_rle_rx: table vectors, directed corner
// sequences and random tokens against a queue-based model.
module tb_delta_rle_rx;

  localparam int PIXW   = 10;
  localparam int BUSW   = 16;
  localparam int LINE_W = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            s_valid;
  logic [BUSW-1:0] s_data;
  logic            s_ready;
  logic            m_valid;
  logic            m_ready;
  logic [PIXW-1:0] m_px;
  logic            m_last;
  logic            run_active;
  logic            err_zero_run;
  logic            err_clr;

  always #5 clk = ~clk;

  delta_rle_rx #(
    .PIXW   (PIXW),
    .BUSW   (BUSW),
    .LINE_W (LINE_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_px         (m_px),
    .m_last       (m_last),
    .run_active   (run_active),
    .err_zero_run (err_zero_run),
    .err_clr      (err_clr)
  );

  typedef struct {
    logic [PIXW-1:0] px;
    logic            last;
  } pix_t;

  typedef struct {
    logic [BUSW-1:0] tok;
    int              npix;
    logic [PIXW-1:0] px;
  } vec_t;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   rdy_mode = 0;

  logic [PIXW-1:0] m_prev = '0;
  int              m_cnt  = 0;
  logic            m_err  = 1'b0;

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic void model_pix(logic [PIXW-1:0] p);
    exp_q.push_back(pix_t'{p, (m_cnt % LINE_W) == LINE_W - 1});
    m_cnt++;
  endfunction

  function automatic void model_tok(logic [BUSW-1:0] t);
    int c;
    if (t[BUSW-1]) begin
      c = int'(t[BUSW-2:0]);
      if (c == 0) m_err = 1'b1;
      for (int i = 0; i < c; i++) model_pix(m_prev);
    end else begin
      m_prev = t[PIXW-1:0];
      model_pix(m_prev);
    end
  endfunction

  function automatic void model_reset();
    m_prev = '0;
    m_cnt  = 0;
    m_err  = 1'b0;
    exp_q.delete();
    got_q.delete();
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = ~m_ready;
    endcase
  end

  logic st_v = 1'b0;
  pix_t st_p;
  always @(negedge clk) begin
    if (!rstn) begin
      st_v = 1'b0;
    end else begin
      if (st_v) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_px", m_px, st_p.px);
        chk("stall_last", m_last, st_p.last);
      end
      if (m_valid && m_ready) got_q.push_back(pix_t'{m_px, m_last});
      st_v = m_valid && !m_ready;
      st_p = pix_t'{m_px, m_last};
    end
  end

  task automatic send(input logic [BUSW-1:0] t, input logic clr = 1'b0);
    int n = 0;
    s_valid = 1'b1;
    s_data  = t;
    err_clr = clr;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("send_accept", s_ready, 1);
    if (s_ready) model_tok(t);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((m_valid || run_active) && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("drain_timeout", n < 500, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(string nm);
    int n;
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({nm, "_px"}, got_q[i].px, exp_q[i].px);
      chk({nm, "_last"}, got_q[i].last, exp_q[i].last);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int nlast;
    int nr_lo;
    int ra_hi;
    int mv_hi;
    int r;
    logic [BUSW-1:0] t;

    vt[0] = '{16'h0123, 1, 10'h123};
    vt[1] = '{16'h8003, 3, 10'h123};
    vt[2] = '{16'h8000, 0, 10'h000};
    vt[3] = '{16'h03FF, 1, 10'h3FF};
    vt[4] = '{16'h8001, 1, 10'h3FF};
    vt[5] = '{16'h0000, 1, 10'h000};
    vt[6] = '{16'h8002, 2, 10'h000};
    vt[7] = '{16'h7C01, 1, 10'h001};

    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    err_clr = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_px", m_px, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_run_active", run_active, 0);
    chk("rst_err", err_zero_run, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("s_ready_after_rst", s_ready, 1);
    @(posedge clk);
    #1;

    // back-to-back literals, latency one
    s_valid = 1'b1;
    s_data  = 16'h0005;
    model_tok(16'h0005);
    @(negedge clk);
    chk("lit_s_ready0", s_ready, 1);
    @(posedge clk);
    #1;
    s_data = 16'h01FF;
    model_tok(16'h01FF);
    @(negedge clk);
    chk("lit_s_ready1", s_ready, 1);
    chk("lit_valid0", m_valid, 1);
    chk("lit_px0", m_px, 10'h005);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("lit_valid1", m_valid, 1);
    chk("lit_px1", m_px, 10'h1FF);
    @(posedge clk);
    #1;
    drain();
    check_stream("lit");

    rdy_mode = 1;
    foreach (vt[i]) begin
      base = got_q.size();
      send(vt[i].tok);
      drain();
      chk("tbl_npix", got_q.size() - base, vt[i].npix);
      if (vt[i].npix > 0) chk("tbl_px", got_q[$].px, vt[i].px);
    end
    check_stream("table");
    chk("tbl_err", err_zero_run, m_err);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    chk("tbl_err_clr", err_zero_run, 0);
    @(posedge clk);
    #1;

    rdy_mode = 0;
    @(posedge clk);
    #1;
    send(16'h00AA);
    send(16'h8004);
    nr_lo = 0;
    ra_hi = 0;
    mv_hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (!s_ready) nr_lo++;
      if (run_active) ra_hi++;
      if (m_valid) mv_hi++;
    end
    @(posedge clk);
    #1;
    chk("run4_s_ready_low", nr_lo, 3);
    chk("run4_run_active", ra_hi, 3);
    chk("run4_valid_cycles", mv_hi, 4);
    check_stream("lit_run");

    rdy_mode = 2;
    send(16'h0155);
    send(16'h8003);
    drain();
    check_stream("stall_run");
    rdy_mode = 0;
    @(posedge clk);
    #1;

    send(16'h8000);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("zero_err_set", err_zero_run, 1);
    chk("zero_no_px", m_valid, 0);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_err   = 1'b0;
    @(negedge clk);
    chk("zero_err_clr", err_zero_run, 0);
    @(posedge clk);
    #1;
    send(16'h8000, 1'b1);
    @(negedge clk);
    chk("zero_set_wins", err_zero_run, 1);
    @(posedge clk);
    #1;
    check_stream("zero_run");

    do_reset();
    send(16'h0001);
    send(16'h8006);
    drain();
    nlast = 0;
    foreach (got_q[i]) if (got_q[i].last) nlast++;
    chk("line_npix", got_q.size(), 7);
    chk("line_nlast", nlast, 1);
    if (got_q.size() >= 4) chk("line_last_4th", got_q[3].last, 1);
    send(16'h0002);
    drain();
    check_stream("line");

    do_reset();
    send(16'h800A);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_run_active", run_active, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", s_ready, 1);
    chk("midrst_no_px", m_valid, 0);
    @(posedge clk);
    #1;
    send(16'h0033);
    drain();
    check_stream("post_rst");

    rdy_mode = 1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      r = $urandom_range(0, 9);
      if (r < 6) t = BUSW'($urandom) & 16'h7FFF;
      else if (r < 9) t = 16'h8000 | BUSW'($urandom_range(0, 5));
      else t = 16'h8000 | BUSW'($urandom_range(6, 25));
      send(t);
    end
    drain();
    check_stream("random");
    chk("random_err", err_zero_run, m_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/delta_rle_rx.md
DELTA_RLE_RX -- requirements
Module: delta_rle_rx

Interface
REQ-001 Parameter PIXW, default 10: bits per pixel channel.
REQ-002 Parameter BUSW, default 16: token width; PIXW <= BUSW-1 SHALL hold (elaboration error otherwise).
REQ-003 Parameter LINE_W, default 3840: pixels per line; LINE_W >= 1.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 s_valid  input  1  token valid.
REQ-007 s_data  input  BUSW  token: bit BUSW-1 = 1 is a run token with count s_data[BUSW-2:0]; bit BUSW-1 = 0 is a literal token with pixel s_data[PIXW-1:0].
REQ-008 s_ready  output  1  token accept.
REQ-009 m_valid  output  1  pixel valid.
REQ-010 m_ready  input  1  downstream accept.
REQ-011 m_px  output  PIXW  pixel value.
REQ-012 m_last  output  1  qualifies m_valid; marks the last pixel of a line.
REQ-013 run_active  output  1  high while a run is expanding.
REQ-014 err_zero_run  output  1  sticky flag: a zero-count run token was received.
REQ-015 err_clr  input  1  synchronous clear of err_zero_run.

Function
REQ-016 The input transfer SHALL occur on s_valid && s_ready; the output transfer SHALL occur on m_valid && m_ready.
REQ-017 The output SHALL be a single register stage; the slot is free when !m_valid || m_ready.
REQ-018 FSM states SHALL be ACCEPT and RUN.
REQ-019 s_ready SHALL equal (state==ACCEPT) && slot free, and SHALL NOT combinationally depend on s_valid.
REQ-020 Literal token accepted in ACCEPT: m_px <= s_data[PIXW-1:0], m_valid <= 1, and the prev register <= the same value; the pixel appears the cycle after acceptance (latency 1).
REQ-021 Run token with count C >= 1 accepted in ACCEPT:
- emit prev on m_px in the next cycle;
- if C == 1, remain in ACCEPT;
- otherwise load remain = C-1 and go to RUN.
REQ-022 In RUN, each cycle the slot is free: emit prev and decrement remain; on the emission where remain reaches 0, return to ACCEPT.
REQ-023 Sustained throughput SHALL be one pixel per cycle with m_ready high, including across a run-to-literal boundary.
REQ-024 Zero-count run token SHALL be accepted and produce no pixel, state SHALL stay ACCEPT, and err_zero_run SHALL be set.
REQ-025 If set and err_clr coincide in the same cycle, set SHALL win.
REQ-026 A run before any literal SHALL repeat the reset value 0.
REQ-027 m_valid, m_px and m_last SHALL hold stable while m_valid && !m_ready.
REQ-028 A column counter SHALL count emitted pixels 0..LINE_W-1 and wrap to 0.
REQ-029 m_last = (col == LINE_W-1); runs MAY cross line boundaries, and m_last SHALL still assert at each line end.
REQ-030 run_active SHALL be high exactly when state==RUN.
REQ-031 remain SHALL be BUSW-1 bits wide; no arithmetic SHALL overflow for C up to 2^(BUSW-1)-1.

Reset
REQ-032 On rstn low: state=ACCEPT, m_valid=0, m_px=0, m_last=0, prev=0, col=0, remain=0, err_zero_run=0, run_active=0.
REQ-033 s_ready SHALL be 0 while rstn is low and 1 in the first cycle after release.
REQ-034 Reset mid-run SHALL abandon the run with no further pixels emitted.

Structure
REQ-035 A shared package delta_rle_pkg SHALL hold the token-type bit position, the state enum (ACCEPT, RUN) and the token field extraction helpers, shared with delta_rle_enc/delta_rle_dec.
REQ-036 The column counter SHALL be one sub-module, line_col_cnt (parameter LINE_W; outputs col and last).

Verification
REQ-037 Literals 0x005, 0x1FF, with m_ready=1 -> m_px 0x005 then 0x1FF, each one cycle after acceptance, s_ready constant 1.
REQ-038 Literal 0x0AA then run C=4 (s_data=0x8004) -> five pixels 0x0AA on consecutive cycles; s_ready low for 3 cycles; run_active high for 3 cycles.
REQ-039 Run C=3 with m_ready toggling 1,0,1,0 -> three pixels, no duplicate or drop, outputs stable while stalled.
REQ-040 s_data=0x8000 -> no pixel, err_zero_run=1 until err_clr is pulsed; err_clr coincident with a second 0x8000 -> flag stays 1.
REQ-041 LINE_W=4: literal 0x001 then run C=6 -> 7 pixels, m_last on the 4th pixel only, col back to 3 at the end.
REQ-042 Assert rstn low during the 2nd cycle of run C=10 -> m_valid=0 immediately; after release, literal 0x033 outputs 0x033 and col restarts at 0.
